// File: rtl/rtc_bus_pkg.sv
// Shared definitions for the RTC multiplexed-bus sequencer: state encoding,
// default phase lengths and the inactive level of the active-low strobes.
package rtc_bus_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    ADDR_SETUP  = 3'd1,
    ADDR_STROBE = 3'd2,
    ADDR_HOLD   = 3'd3,
    GAP         = 3'd4,
    DATA_STROBE = 3'd5,
    DATA_HOLD   = 3'd6,
    DONE        = 3'd7
  } rtc_state_t;

  // Default phase lengths in clock cycles
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_T_SETUP = 1;
  localparam int DEF_T_ADDR  = 5;
  localparam int DEF_T_HOLD  = 1;
  localparam int DEF_T_GAP   = 5;
  localparam int DEF_T_DATA  = 6;
  localparam int DEF_CNT_W   = 5;

  // a_d, cs, wr and rd all rest high
  localparam logic STROBE_OFF = 1'b1;

  // A phase length is usable when it is at least one cycle and its
  // reload value (length-1) fits in the phase counter.
  function automatic bit timing_fits(input int t, input int w);
    return (t >= 1) && ((t - 1) < (1 << w));
  endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// Loadable down-counter that measures the length of one bus phase.
// Loading T-1 on phase entry makes the zero flag rise in the phase's last cycle.
module rtc_phase_timer #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  output logic             zero
);

  logic [CNT_W-1:0] count_reg;

  // Reload on phase entry, otherwise count down and rest at zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/rtc_bus_sequencer.sv
// Runs one address-phase + data-phase transaction on the RTC multiplexed bus
// per accepted start. Every pin-facing output is registered and decoded from
// the next state, so the pins change exactly on the clock edge that enters a phase.
module rtc_bus_sequencer
  import rtc_bus_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int T_SETUP = DEF_T_SETUP,
  parameter int T_ADDR  = DEF_T_ADDR,
  parameter int T_HOLD  = DEF_T_HOLD,
  parameter int T_GAP   = DEF_T_GAP,
  parameter int T_DATA  = DEF_T_DATA,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              rw,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              reg_a_d,
  output logic              reg_cs,
  output logic              reg_wr,
  output logic              reg_rd,
  output logic              bus_oe,
  output logic [DATA_W-1:0] bus_dout,
  input  logic [DATA_W-1:0] bus_din
);

  // Zero-length phases or counters too narrow for a phase cannot be built
  if (!(timing_fits(T_SETUP, CNT_W) && timing_fits(T_ADDR, CNT_W) &&
        timing_fits(T_HOLD, CNT_W) && timing_fits(T_GAP, CNT_W) &&
        timing_fits(T_DATA, CNT_W))) begin : g_bad_timing
    $error("rtc_bus_sequencer: every phase length must be >= 1 and fit CNT_W");
  end

  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] LD_ADDR  = CNT_W'(T_ADDR - 1);
  localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(T_HOLD - 1);
  localparam logic [CNT_W-1:0] LD_GAP   = CNT_W'(T_GAP - 1);
  localparam logic [CNT_W-1:0] LD_DATA  = CNT_W'(T_DATA - 1);

  rtc_state_t        state_reg, state_next;
  logic              timer_load;
  logic [CNT_W-1:0]  timer_value;
  logic              timer_zero;

  logic              rw_reg;
  logic [DATA_W-1:0] addr_reg, wdata_reg;
  logic              rw_cur;
  logic [DATA_W-1:0] addr_cur, wdata_cur;

  logic              a_d_next, cs_next, wr_next, rd_next, oe_next;
  logic [DATA_W-1:0] dout_next;
  logic              a_d_reg, cs_reg, wr_reg, rd_reg, oe_reg;
  logic [DATA_W-1:0] dout_reg, rdata_reg;
  logic              busy_reg, done_reg, rdata_valid_reg;

  rtc_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (timer_load),
    .load_value (timer_value),
    .zero       (timer_zero)
  );

  // The accept cycle decodes outputs before the request fields are latched,
  // so it reads them straight from the inputs.
  assign rw_cur    = (state_reg == IDLE) ? rw    : rw_reg;
  assign addr_cur  = (state_reg == IDLE) ? addr  : addr_reg;
  assign wdata_cur = (state_reg == IDLE) ? wdata : wdata_reg;

  // Phase sequencing: advance when the timer expires and reload it for the new phase
  always_comb begin
    state_next  = state_reg;
    timer_load  = 1'b0;
    timer_value = '0;
    case (state_reg)
      IDLE: if (start) begin
        state_next = ADDR_SETUP;  timer_load = 1'b1; timer_value = LD_SETUP;
      end
      ADDR_SETUP: if (timer_zero) begin
        state_next = ADDR_STROBE; timer_load = 1'b1; timer_value = LD_ADDR;
      end
      ADDR_STROBE: if (timer_zero) begin
        state_next = ADDR_HOLD;   timer_load = 1'b1; timer_value = LD_HOLD;
      end
      ADDR_HOLD: if (timer_zero) begin
        state_next = GAP;         timer_load = 1'b1; timer_value = LD_GAP;
      end
      GAP: if (timer_zero) begin
        state_next = DATA_STROBE; timer_load = 1'b1; timer_value = LD_DATA;
      end
      DATA_STROBE: if (timer_zero) begin
        state_next = DATA_HOLD;   timer_load = 1'b1; timer_value = LD_HOLD;
      end
      DATA_HOLD: if (timer_zero) begin
        state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Pin levels for the phase being entered; the bus is only driven for addresses and write data
  always_comb begin
    a_d_next  = STROBE_OFF;
    cs_next   = STROBE_OFF;
    wr_next   = STROBE_OFF;
    rd_next   = STROBE_OFF;
    oe_next   = 1'b0;
    dout_next = '0;
    case (state_next)
      ADDR_SETUP, ADDR_HOLD: begin
        a_d_next  = 1'b0;
        oe_next   = 1'b1;
        dout_next = addr_cur;
      end
      ADDR_STROBE: begin
        a_d_next  = 1'b0;
        cs_next   = 1'b0;
        wr_next   = 1'b0;
        oe_next   = 1'b1;
        dout_next = addr_cur;
      end
      DATA_STROBE: begin
        cs_next = 1'b0;
        if (rw_cur) begin
          wr_next   = 1'b0;
          oe_next   = 1'b1;
          dout_next = wdata_cur;
        end else begin
          rd_next = 1'b0;
        end
      end
      DATA_HOLD: if (rw_cur) begin
        oe_next   = 1'b1;
        dout_next = wdata_cur;
      end
      default: ;
    endcase
  end

  // State, latched request, registered pins, handshake and read capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= IDLE;
      rw_reg          <= 1'b0;
      addr_reg        <= '0;
      wdata_reg       <= '0;
      a_d_reg         <= STROBE_OFF;
      cs_reg          <= STROBE_OFF;
      wr_reg          <= STROBE_OFF;
      rd_reg          <= STROBE_OFF;
      oe_reg          <= 1'b0;
      dout_reg        <= '0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      rdata_valid_reg <= 1'b0;
      rdata_reg       <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && start) begin
        rw_reg    <= rw;
        addr_reg  <= addr;
        wdata_reg <= wdata;
      end
      a_d_reg         <= a_d_next;
      cs_reg          <= cs_next;
      wr_reg          <= wr_next;
      rd_reg          <= rd_next;
      oe_reg          <= oe_next;
      dout_reg        <= dout_next;
      busy_reg        <= (state_next != IDLE);
      done_reg        <= (state_next == DONE);
      rdata_valid_reg <= (state_next == DONE) && !rw_cur;
      // Sample the chip's data on the edge that ends the read strobe
      if (state_reg == DATA_STROBE && state_next != DATA_STROBE && !rw_reg) begin
        rdata_reg <= bus_din;
      end
    end
  end

  assign reg_a_d     = a_d_reg;
  assign reg_cs      = cs_reg;
  assign reg_wr      = wr_reg;
  assign reg_rd      = rd_reg;
  assign bus_oe      = oe_reg;
  assign bus_dout    = dout_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;
  assign rdata_valid = rdata_valid_reg;
  assign rdata       = rdata_reg;

endmodule

// File: doc/rtc_bus_sequencer.md
Name: rtc_bus_sequencer

Overview:
Parametrised successor to the fixed 20-count RTC control-signal generator. Runs one complete multiplexed-bus transaction (address phase then data phase) to the RTC chip per start request. It drives the a_d, cs, wr and rd strobes and the bidirectional-bus enable/data, and captures read data. All phase lengths are parameters, and the block adds a busy/done handshake and latched read data; it sits between the RTC command controller and the chip pins.

Parameters:
DATA_W, 8, width of address/data on multiplexed bus
T_SETUP, 1, cycles a_d low before cs asserts (address setup)
T_ADDR, 5, cycles cs/wr low during address strobe
T_HOLD, 1, cycles strobes released with bus still driven (address and data hold)
T_GAP, 5, idle cycles between address and data phases
T_DATA, 6, cycles cs and wr/rd low during data strobe
CNT_W, 5, phase-counter width; must hold max(T_*)-1

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
start  in  1  request a transaction; sampled only in IDLE
rw  in  1  1=write, 0=read; latched with start
addr  in  DATA_W  register address; latched with start
wdata  in  DATA_W  write data; latched with start
busy  out  1  high from accept until the DONE cycle, inclusive
done  out  1  one-cycle pulse at end of transaction
rdata  out  DATA_W  last captured read data
rdata_valid  out  1  one-cycle pulse with done, read transactions only
reg_a_d  out  1  address/data select (0=address)
reg_cs  out  1  chip select, active low
reg_wr  out  1  write strobe, active low
reg_rd  out  1  read strobe, active low
bus_oe  out  1  1=drive bus_dout onto pins
bus_dout  out  DATA_W  value driven on bus
bus_din  in  DATA_W  pin value for reads

Behaviour:
- Reset (async, while reset=0): state IDLE; reg_a_d=reg_cs=reg_wr=reg_rd=1; bus_oe=0; bus_dout=0; busy=done=rdata_valid=0; rdata=0. Mid-transaction reset deasserts all strobes immediately, with no completion pulse.
- All outputs are registered (decoded from next state). Cycle n means the n-th cycle after the edge that accepts start.
- States and outputs:
  IDLE: strobes 1, oe 0. On start=1: latch rw/addr/wdata, go to ADDR_SETUP.
  ADDR_SETUP (T_SETUP): a_d=0, cs/wr/rd=1, oe=1, dout=addr.
  ADDR_STROBE (T_ADDR): a_d=0, cs=0, wr=0, rd=1, oe=1, dout=addr.
  ADDR_HOLD (T_HOLD): a_d=0, cs/wr/rd=1, oe=1, dout=addr.
  GAP (T_GAP): a_d=1, cs/wr/rd=1, oe=0.
  DATA_STROBE (T_DATA): a_d=1, cs=0. Write: wr=0, rd=1, oe=1, dout=wdata. Read: rd=0, wr=1, oe=0.
  DATA_HOLD (T_HOLD): a_d=1, cs/wr/rd=1. Write: oe=1, dout=wdata. Read: oe=0.
  DONE (1 cycle): strobes 1, oe 0, done=1, rdata_valid=rw==0; then go to IDLE.
- Phase timer: on phase entry, load T_x-1 and decrement each cycle; advance when it reaches 0. All T_x must be >=1; T_x=0 is illegal (simulation assertion).
- Read capture: rdata <= bus_din on the clock edge that leaves DATA_STROBE, i.e. the value present in the last DATA_STROBE cycle. rdata holds until the next read capture; writes do not alter it.
- Latency, accept to done: T_SETUP+T_ADDR+T_HOLD+T_GAP+T_DATA+T_HOLD+1. With defaults this is 20.
- start while busy is ignored (no queueing). start held high is accepted in the first IDLE cycle after DONE, so back-to-back transactions have 1 IDLE cycle between them.
- addr/wdata/rw changes after accept have no effect.
- wr and rd are never low in the same cycle. cs is never low while a_d is changing.

Decomposition:
- Package rtc_bus_pkg: state encoding localparams (IDLE, ADDR_SETUP, ADDR_STROBE, ADDR_HOLD, GAP, DATA_STROBE, DATA_HOLD, DONE), default timing constants, strobe-inactive constant.
- Sub-module rtc_phase_timer: loadable CNT_W-bit down-counter with zero flag.

Test Plan:
- Defaults, write addr=0x0A wdata=0x26 → a_d low cycles 1-7; cs/wr low cycles 2-6 and 13-18; dout=0x0A in cycles 1-7 and 0x26 in cycles 13-19; oe=0 in cycles 8-12; done=1 at cycle 20; rdata_valid=0; rdata unchanged.
- Defaults, read addr=0x00, bus_din=0x11 in cycle 17 and 0x59 in cycle 18 → rd low cycles 13-18, wr high; oe=0 in cycles 8-20; rdata=0x59 and rdata_valid=1 at cycle 20.
- start pulsed at cycles 5 and 12 of an active transaction → ignored, no second transaction. start held continuously → second accept on the IDLE cycle after done, so the second a_d falls at cycle 22.
- reset driven low during cycle 4 (ADDR_STROBE) → cs/wr/a_d=1 and oe=0 before the next edge; no done; after release a new start yields the full 20-cycle sequence.
- Override T_ADDR=2, T_GAP=1, T_DATA=3, read → cs low cycles 2-3 and 6-8; done at cycle 10; rdata = bus_din of cycle 8.
- Random 200 transactions with a bus model → read data matches the model; wr&rd never both 0; cs never 0 on an a_d edge.
